// File: rtl/lcd_msg_arbiter.sv
`default_nettype none
// ============================================================================
// lcd_msg_arbiter : round-robin share of one 16x2 LCD driver between A and B
// Revision 1.0
// ============================================================================
module lcd_msg_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_a,
    input  logic [127:0] a_line1,
    input  logic [127:0] a_line2,
    input  logic         req_b,
    input  logic [127:0] b_line1,
    input  logic [127:0] b_line2,
    output logic [1:0]   gnt,
    output logic [127:0] lcd_line1,
    output logic [127:0] lcd_line2,
    output logic         lcd_update,
    input  logic         lcd_ready,
    input  logic         lcd_done
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LOAD     = 2'd1;
    localparam logic [1:0] c_WAIT_LCD = 2'd2;
    localparam logic [1:0] c_HOLD     = 2'd3;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [127:0]     c_BLANK     = {16{8'h20}};

    logic [1:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [127:0]     line1_q, line1_d;
    logic [127:0]     line2_q, line2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;

    logic w_pick_b;
    logic w_owner_req;

    // B wins only when A is idle, or on a tie when A owned the display last.
    assign w_pick_b    = req_b & (~req_a | ~last_b_q);
    assign w_owner_req = (gnt_q[0] & req_a) | (gnt_q[1] & req_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= c_IDLE;
            gnt_q    <= 2'b00;
            line1_q  <= c_BLANK;
            line2_q  <= c_BLANK;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        line1_d  = line1_q;
        line2_d  = line2_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        case (state_q)
            c_IDLE: begin
                if (req_a | req_b) begin
                    state_d = c_LOAD;
                    if (w_pick_b) begin
                        gnt_d   = 2'b10;
                        line1_d = b_line1;
                        line2_d = b_line2;
                    end else begin
                        gnt_d   = 2'b01;
                        line1_d = a_line1;
                        line2_d = a_line2;
                    end
                end
            end
            c_LOAD: begin
                if (lcd_ready) begin
                    state_d = c_WAIT_LCD;
                end
            end
            c_WAIT_LCD: begin
                if (lcd_done) begin
                    state_d = c_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q != c_HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((cnt_q == c_HOLD_LAST) || !w_owner_req) begin
                    state_d  = c_IDLE;
                    gnt_d    = 2'b00;
                    last_b_d = gnt_q[1];
                end
            end
        endcase
    end

    always_comb begin
        lcd_update = (state_q == c_LOAD);
        gnt        = gnt_q;
        lcd_line1  = line1_q;
        lcd_line2  = line2_q;
    end

endmodule
`default_nettype wire
